// File: rtl/common.sv
// Shared RV32I pipeline types: instruction word, fetch buffer entry, reset PC.
package common;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [31:0] instruction_type;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type instruction;
  } fetch_entry_type;
endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries with flush (flush overrides push); head visible the cycle after push.
// A push while full is taken only together with a pop in the same cycle.
module fetch_buffer import common::*; #(
  parameter int BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  fetch_entry_type             push_entry,
  input  logic                        pop,
  input  logic                        flush,
  output fetch_entry_type             head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(BUF_DEPTH):0]  count
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH = BUF_DEPTH[AW:0];

  fetch_entry_type mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: PC, credit-limited imem requests, instruction buffer to decode; FETCH_MISALIGN_CHECK_EN adds misaligned-redirect fault.
// Latency: memory latency + 1 to decode; dec_ready low stalls via buffer credits, redirect flushes and drops in-flight responses.
module fetch_stage import common::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instruction,
  output logic [31:0] dec_pc,
  output logic        fetch_fault
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH = BUF_DEPTH[CW:0];

  logic [31:0]     req_pc;
  logic [31:0]     rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight_next;
  logic [CW:0]     committed;
  logic [31:0]     target;
  logic            fault;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            unused_full;
  fetch_entry_type head;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target = redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst)          fault <= 1'b0;
    else if (redirect) fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target          = {redirect_pc[31:2], 2'b00};
  assign fault           = 1'b0;
`endif

  assign unused_full = full;

  // Credit counts the slot freed by this cycle's pop so a 2-entry buffer sustains one fetch per cycle.
  assign committed      = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst && !redirect && !fault && (committed < DEPTH);
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inflight_next  = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign push = imem_rsp_valid && (drop == '0);
  assign pop  = dec_ready && !empty;

  assign dec_valid       = !empty;
  assign dec_instruction = empty ? '0 : head.instruction;
  assign dec_pc          = empty ? '0 : head.pc;
  assign fetch_fault     = fault;

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= inflight_next;
      if (redirect) begin
        req_pc <= target;
        rsp_pc <= target;
        drop   <= inflight_next;
      end else begin
        if (req_fire) req_pc <= req_pc + 32'd4;
        if (imem_rsp_valid) begin
          if (drop != '0) drop   <= drop - 1'b1;
          else            rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ({rsp_pc, imem_rsp_data}),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );
endmodule
